// File: rtl/fft_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one FFT stage engine between NUM_REQ streams.
// Optional perf counters (frame_count, stall_count) are built when FFT_FRAME_ARB_PERF_EN is defined.
module fft_frame_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int FRAME_LEN = 128,
  parameter int DATA_W    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       eng_in_valid,
  output logic [DATA_W-1:0]          eng_in_data,
  input  logic                       eng_in_ready,
  input  logic                       eng_out_valid,
  input  logic [DATA_W-1:0]          eng_out_data,
  output logic                       eng_out_ready,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [DATA_W-1:0]          resp_data,
  input  logic [NUM_REQ-1:0]         resp_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
`ifdef FFT_FRAME_ARB_PERF_EN
  ,
  output logic [31:0]                frame_count,
  output logic [31:0]                stall_count
`endif
);

  localparam int GID_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_RECV = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [GID_W-1:0] r_grant;
  logic [GID_W-1:0] r_last;

  logic [GID_W-1:0]  w_rot_idx [NUM_REQ];
  logic [DATA_W-1:0] w_req_beat [NUM_REQ];
  logic              w_any;
  logic [GID_W-1:0]  w_pick;
  logic              w_in_hs;
  logic              w_out_hs;
  logic              w_last_beat;
  logic              w_frame_done;

  // w_rot_idx[k] is the requester k+1 places after the previous owner.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign w_rot_idx[gi]  = GID_W'((int'(r_last) + gi + 1) % NUM_REQ);
    assign w_req_beat[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Scan from the farthest candidate down so the nearest requester wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[w_rot_idx[k]]) begin
        w_any  = 1'b1;
        w_pick = w_rot_idx[k];
      end
    end
  end

  always_comb begin
    req_ready     = '0;
    eng_in_valid  = 1'b0;
    eng_in_data   = '0;
    eng_out_ready = 1'b0;
    resp_valid    = '0;
    resp_data     = '0;
    case (r_state)
      S_SEND: begin
        eng_in_valid       = req_valid[r_grant];
        req_ready[r_grant] = eng_in_ready;
        if (req_valid[r_grant]) eng_in_data = w_req_beat[r_grant];
      end
      S_RECV: begin
        resp_valid[r_grant] = eng_out_valid;
        eng_out_ready       = resp_ready[r_grant];
        if (eng_out_valid) resp_data = eng_out_data;
      end
      default: ;
    endcase
  end

  assign w_in_hs      = eng_in_valid & eng_in_ready;
  assign w_out_hs     = eng_out_valid & eng_out_ready;
  assign w_last_beat  = (r_cnt == LAST_BEAT);
  assign w_frame_done = (r_state == S_RECV) && w_out_hs && w_last_beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_grant <= '0;
      r_last  <= GID_W'(NUM_REQ - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_cnt   <= '0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_in_hs) begin
            if (w_last_beat) begin
              r_cnt   <= '0;
              r_state <= S_RECV;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_RECV: begin
          if (w_out_hs) begin
            if (w_last_beat) begin
              r_last  <= r_grant;
              r_grant <= '0;
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant_id = r_grant;
  assign busy     = (r_state != S_IDLE);

`ifdef FFT_FRAME_ARB_PERF_EN
  logic [31:0] r_frame_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = ((r_state == S_SEND) && !w_in_hs) || ((r_state == S_RECV) && !w_out_hs);

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_frame_done && (r_frame_cnt != 32'hFFFF_FFFF)) r_frame_cnt <= r_frame_cnt + 32'd1;
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign frame_count = r_frame_cnt;
  assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Directed bench for fft_frame_arbiter: frame scenarios from a vector table plus hand-written
// mid-frame reset and back-to-back sequences, with an echo engine (result = beat + 1).
module tb_fft_frame_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int FRAME_LEN = 128;
  localparam int DATA_W    = 64;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      eng_in_valid;
  logic [DATA_W-1:0]         eng_in_data;
  logic                      eng_in_ready;
  logic                      eng_out_valid;
  logic [DATA_W-1:0]         eng_out_data;
  logic                      eng_out_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_data;
  logic [NUM_REQ-1:0]        resp_ready;
  logic [1:0]                grant_id;
  logic                      busy;
`ifdef FFT_FRAME_ARB_PERF_EN
  logic [31:0]               frame_count;
  logic [31:0]               stall_count;
`endif

  fft_frame_arbiter #(.NUM_REQ(NUM_REQ), .FRAME_LEN(FRAME_LEN), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .eng_in_valid(eng_in_valid), .eng_in_data(eng_in_data), .eng_in_ready(eng_in_ready),
    .eng_out_valid(eng_out_valid), .eng_out_data(eng_out_data), .eng_out_ready(eng_out_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .grant_id(grant_id), .busy(busy)
`ifdef FFT_FRAME_ARB_PERF_EN
    , .frame_count(frame_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       do_reset;
    logic [3:0] mask;
    int         bubble_at;
    int         bubble_len;
    logic       toggle;
    int         exp_grant;
  } vec_t;

  vec_t vecs [9];
  vec_t perf_vecs [3];

  int checks = 0;
  int errors = 0;

  logic [3:0]  req_en;
  int          req_idx  [NUM_REQ];
  int          resp_idx [NUM_REQ];
  logic [63:0] eng_q [$];
  int          in_cnt, out_cnt, send_cyc, recv_cyc;
  logic        toggle_en, tog_phase;
  logic        cap_busy, cap_in_valid;
  logic [1:0]  cap_grant;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic void drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = req_en[i];
      req_data[i*DATA_W +: DATA_W] = {32'(i), 32'(req_idx[i])};
    end
    eng_in_ready  = 1'b1;
    eng_out_valid = (eng_q.size() > 0);
    eng_out_data  = (eng_q.size() > 0) ? eng_q[0] + 64'd1 : 64'd0;
    resp_ready    = toggle_en ? {4{tog_phase}} : 4'hF;
  endfunction

  // One clock: sample/check at negedge, then advance the models and drive just after posedge.
  task automatic step();
    int          g;
    logic        in_hs, out_hs;
    logic [63:0] din;
    @(negedge clk);
    g            = int'(grant_id);
    cap_busy     = busy;
    cap_grant    = grant_id;
    cap_in_valid = eng_in_valid;
    in_hs        = eng_in_valid & eng_in_ready;
    out_hs       = eng_out_valid & eng_out_ready;
    din          = eng_in_data;
    if (!busy) begin
      chk("idle_ctl", 64'({eng_in_valid, eng_out_ready, req_ready, resp_valid, grant_id}), 64'd0);
      chk("idle_data", eng_in_data | resp_data, 64'd0);
    end
    chk("req_ready_iso", 64'(req_ready & ~(4'b0001 << g)), 64'd0);
    if (busy && in_cnt < FRAME_LEN) begin
      send_cyc++;
      chk("early_out_ready", 64'(eng_out_ready), 64'd0);
    end
    if (busy && in_cnt == FRAME_LEN) begin
      recv_cyc++;
      chk("recv_out_ready", 64'({eng_out_ready, req_ready}), 64'({resp_ready[g], 4'b0000}));
    end
    if (in_hs) chk("in_data", din, {32'(g), 32'(req_idx[g])});
    if (out_hs) begin
      chk("resp_valid", 64'(resp_valid), 64'(4'b0001 << g));
      chk("resp_data", resp_data, {32'(g), 32'(resp_idx[g] + 1)});
    end
    @(posedge clk);
    #1;
    if (rst) begin
      eng_q.delete();
      for (int i = 0; i < NUM_REQ; i++) begin
        req_idx[i]  = 0;
        resp_idx[i] = 0;
      end
      in_cnt  = 0;
      out_cnt = 0;
    end else begin
      if (in_hs) begin
        req_idx[g]++;
        eng_q.push_back(din);
        in_cnt++;
      end
      if (out_hs) begin
        void'(eng_q.pop_front());
        resp_idx[g]++;
        out_cnt++;
      end
    end
    tog_phase = ~tog_phase;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_en = '0;
    drive();
    step();
    step();
    chk("reset_busy", 64'(cap_busy), 64'd0);
    chk("reset_grant", 64'(cap_grant), 64'd0);
    rst = 1'b0;
    drive();
  endtask

  task automatic run_frame(input vec_t v);
    int   g;
    int   guard;
    logic bub_done;
    if (v.do_reset) do_reset();
    in_cnt = 0; out_cnt = 0; send_cyc = 0; recv_cyc = 0;
    toggle_en = v.toggle;
    req_en = v.mask;
    drive();
    step();
    chk("arb_cycle_busy", 64'(cap_busy), 64'd0);
    step();
    chk("busy_rise", 64'(cap_busy), 64'd1);
    chk("grant", 64'(cap_grant), 64'(v.exp_grant));
    g = v.exp_grant;
    bub_done = (v.bubble_len == 0);
    guard = 0;
    while (cap_busy && guard < 2000) begin
      if (!bub_done && in_cnt == v.bubble_at) begin
        req_en[g] = 1'b0;
        drive();
        for (int b = 0; b < v.bubble_len; b++) begin
          step();
          chk("bubble_valid", 64'(cap_in_valid), 64'd0);
          chk("bubble_hold", 64'(in_cnt), 64'(v.bubble_at));
          chk("bubble_grant", 64'(cap_grant), 64'(g));
        end
        req_en[g] = 1'b1;
        drive();
        bub_done = 1'b1;
      end
      if (in_cnt == FRAME_LEN && req_en != 4'b0000) begin
        req_en = '0;
        drive();
      end
      step();
      guard++;
    end
    chk("frame_timeout", 64'(guard < 2000), 64'd1);
    chk("frame_in_beats", 64'(in_cnt), 64'(FRAME_LEN));
    chk("frame_out_beats", 64'(out_cnt), 64'(FRAME_LEN));
    chk("send_cycles", 64'(send_cyc), 64'(FRAME_LEN + v.bubble_len));
    if (v.toggle) chk("recv_cycles_toggle", 64'(recv_cyc >= 2*FRAME_LEN-1 && recv_cyc <= 2*FRAME_LEN), 64'd1);
    else          chk("recv_cycles", 64'(recv_cyc), 64'(FRAME_LEN));
    $display("frame mask=%b grant=%0d in=%0d out=%0d send_cyc=%0d recv_cyc=%0d",
             v.mask, cap_grant, in_cnt, out_cnt, send_cyc, recv_cyc);
  endtask

  initial begin
    //          rst    mask     b_at b_len tog   grant
    vecs[0] = '{1'b1, 4'b0100, 0,   0,    1'b0, 2};
    vecs[1] = '{1'b1, 4'b1111, 0,   0,    1'b0, 0};
    vecs[2] = '{1'b0, 4'b1111, 40,  5,    1'b0, 1};
    vecs[3] = '{1'b0, 4'b1111, 0,   0,    1'b0, 2};
    vecs[4] = '{1'b0, 4'b1111, 0,   0,    1'b0, 3};
    vecs[5] = '{1'b0, 4'b1111, 0,   0,    1'b1, 0};
    vecs[6] = '{1'b0, 4'b1010, 0,   0,    1'b0, 1};
    vecs[7] = '{1'b0, 4'b1001, 0,   0,    1'b0, 3};
    vecs[8] = '{1'b0, 4'b0001, 0,   0,    1'b0, 0};
    perf_vecs[0] = '{1'b0, 4'b1111, 0,  0,  1'b0, 0};
    perf_vecs[1] = '{1'b0, 4'b1111, 20, 10, 1'b0, 1};
    perf_vecs[2] = '{1'b0, 4'b1111, 0,  0,  1'b0, 2};

    rst = 1'b1; req_en = '0; toggle_en = 1'b0; tog_phase = 1'b0;
    in_cnt = 0; out_cnt = 0; send_cyc = 0; recv_cyc = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_idx[i] = 0;
      resp_idx[i] = 0;
    end
    drive();
    do_reset();

    for (int v = 0; v < 9; v++) run_frame(vecs[v]);

    // Reset in the middle of a frame: partial frame discarded, arbitration restarts at requester 0.
    begin
      int guard = 0;
      in_cnt = 0; out_cnt = 0; toggle_en = 1'b0;
      req_en = 4'b0100;
      drive();
      step();
      step();
      chk("midrst_grant", 64'(cap_grant), 64'd2);
      while (in_cnt < 64 && guard < 500) begin
        step();
        guard++;
      end
      chk("midrst_reach64", 64'(in_cnt), 64'd64);
      rst = 1'b1;
      drive();
      step();
      step();
      chk("midrst_busy", 64'(cap_busy), 64'd0);
      chk("midrst_grant0", 64'(cap_grant), 64'd0);
      rst = 1'b0;
      req_en = '0;
      drive();
      $display("midframe reset at beat 64 busy=%0d grant=%0d", cap_busy, cap_grant);
    end

    for (int v = 0; v < 3; v++) run_frame(perf_vecs[v]);
`ifdef FFT_FRAME_ARB_PERF_EN
    chk("frame_count", 64'(frame_count), 64'd3);
    chk("stall_count", 64'(stall_count), 64'd10);
    $display("perf frame_count=%0d stall_count=%0d", frame_count, stall_count);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
